// File: rtl/alu_mul_seq.sv
// Unsigned WIDTH x WIDTH -> 2*WIDTH shift-add multiplier sequencer that borrows the shared ALU.
// Latency: start accepted at edge 0, RUN for WIDTH cycles, done pulses the cycle after RUN.
// Backpressure: none; start is ignored while busy, and the pipeline stalls on o_busy.
//
// Ports:
//   i_clk, i_rst_n             clock, asynchronous active-low reset
//   i_start, i_op_a, i_op_b    request and operands (captured when start is accepted)
//   o_busy, o_done, o_product  status, one-cycle completion pulse, held result
//   o_alu_a, o_alu_b, o_alu_ctrl  operand/control drive to the external ALU
//   i_alu_result, i_alu_carry  combinational ALU sum and carry out
module alu_mul_seq #(
  parameter int          WIDTH   = 32,
  parameter int          CNT_W   = 5,
  parameter logic [2:0]  ALU_ADD = 3'b000
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic [WIDTH-1:0]     i_op_a,
  input  logic [WIDTH-1:0]     i_op_b,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [2*WIDTH-1:0]   o_product,
  output logic [WIDTH-1:0]     o_alu_a,
  output logic [WIDTH-1:0]     o_alu_b,
  output logic [2:0]           o_alu_ctrl,
  input  logic [WIDTH-1:0]     i_alu_result,
  input  logic                 i_alu_carry
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CNT_W-1:0]     r_cnt;
  logic [WIDTH-1:0]     r_mcand;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;
  logic [2*WIDTH-1:0]   r_product;
  logic                 r_done;

  logic                 w_last;
  logic [2*WIDTH-1:0]   w_acc_nxt;

  assign w_last    = (r_cnt == CNT_W'(WIDTH-1));
  // One step of the (2*WIDTH+1)-bit right shift of {carry, sum, lo}; lo[0] drops out.
  assign w_acc_nxt = {i_alu_carry, i_alu_result, r_lo[WIDTH-1:1]};

  assign o_busy    = (r_state == RUN);
  assign o_done    = r_done;
  assign o_product = r_product;

  always_comb begin
    w_state_nxt = r_state;
    o_alu_a     = '0;
    o_alu_b     = '0;
    o_alu_ctrl  = ALU_ADD;
    case (r_state)
      IDLE: begin
        if (i_start) w_state_nxt = RUN;
      end
      RUN: begin
        o_alu_a = r_hi;
        o_alu_b = r_lo[0] ? r_mcand : '0;
        if (w_last) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_mcand   <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_product <= '0;
      r_done    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_mcand <= i_op_a;
            r_lo    <= i_op_b;
            r_hi    <= '0;
            r_cnt   <= '0;
          end
        end
        RUN: begin
          {r_hi, r_lo} <= w_acc_nxt;
          r_cnt        <= r_cnt + 1'b1;
          if (w_last) begin
            r_product <= w_acc_nxt;
            r_done    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mul_seq.sv
module tb_alu_mul_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        done;
  logic [63:0] product;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_ctrl;
  logic [31:0] alu_result;
  logic        alu_carry;
  logic [32:0] alu_sum;

  int checks = 0;
  int errors = 0;

  alu_mul_seq #(.WIDTH(32), .CNT_W(5), .ALU_ADD(3'b000)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (start),
    .i_op_a       (op_a),
    .i_op_b       (op_b),
    .o_busy       (busy),
    .o_done       (done),
    .o_product    (product),
    .o_alu_a      (alu_a),
    .o_alu_b      (alu_b),
    .o_alu_ctrl   (alu_ctrl),
    .i_alu_result (alu_result),
    .i_alu_carry  (alu_carry)
  );

  // Stand-in for the shared ALU: only ADD is needed here.
  always_comb begin
    alu_sum = '0;
    if (alu_ctrl == 3'b000) alu_sum = {1'b0, alu_a} + {1'b0, alu_b};
  end
  assign alu_result = alu_sum[31:0];
  assign alu_carry  = alu_sum[32];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulses start for one cycle, then counts busy cycles up to and including the done cycle.
  task automatic do_mul(input logic [31:0] a, input logic [31:0] b,
                        output int nbusy, output bit got_done, output logic [63:0] prod);
    @(negedge clk);
    start = 1'b1; op_a = a; op_b = b;
    @(negedge clk);
    start = 1'b0;
    nbusy = 0; got_done = 1'b0; prod = '0;
    for (int i = 0; i < 100; i++) begin
      if (busy) nbusy++;
      if (done) begin
        got_done = 1'b1;
        prod = product;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic check_run(input string name, input int nbusy, input bit got_done,
                           input logic [63:0] prod, input logic [63:0] exp);
    checks++;
    if (got_done !== 1'b1) begin
      errors++; $display("FAIL %s_done_timeout got=%0d want=1", name, got_done);
    end
    checks++;
    if (nbusy !== 32) begin
      errors++; $display("FAIL %s_busy_cycles got=%0d want=32", name, nbusy);
    end
    checks++;
    if (prod !== exp) begin
      errors++; $display("FAIL %s_product got=%h want=%h", name, prod, exp);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; op_a = '0; op_b = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL reset_status got busy=%b done=%b want 0 0", busy, done);
    end
    checks++;
    if (product !== 64'd0) begin
      errors++; $display("FAIL reset_product got=%h want=0", product);
    end
    checks++;
    if (alu_a !== 32'd0 || alu_b !== 32'd0 || alu_ctrl !== 3'b000) begin
      errors++; $display("FAIL reset_alu got a=%h b=%h c=%b want 0 0 000", alu_a, alu_b, alu_ctrl);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int n; bit g; logic [63:0] p;
    do_mul(32'd3, 32'd5, n, g, p);
    check_run("basic", n, g, p, 64'd15);
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || product !== 64'd15) begin
      errors++; $display("FAIL basic_after got done=%b product=%h want 0 15", done, product);
    end
  endtask

  task automatic test_carry;
    int n; bit g; logic [63:0] p;
    do_mul(32'hFFFFFFFF, 32'hFFFFFFFF, n, g, p);
    check_run("carry", n, g, p, 64'hFFFFFFFE_00000001);
    do_mul(32'h80000000, 32'h00000003, n, g, p);
    check_run("carry2", n, g, p, 64'h00000001_80000000);
  endtask

  task automatic test_zero;
    int n; bit g; logic [63:0] p;
    do_mul(32'd0, 32'h12345678, n, g, p);
    check_run("zero_a", n, g, p, 64'd0);
    do_mul(32'd123456, 32'd1000, n, g, p);
    check_run("nonzero", n, g, p, 64'd123456000);
    do_mul(32'hDEADBEEF, 32'd0, n, g, p);
    check_run("zero_b", n, g, p, 64'd0);
  endtask

  task automatic test_ignore_start;
    int n; int ndone; bit g; logic [63:0] p;
    @(negedge clk);
    start = 1'b1; op_a = 32'd7; op_b = 32'd9;
    @(negedge clk);
    start = 1'b0;
    n = 0; g = 1'b0; p = '0;
    for (int i = 0; i < 100; i++) begin
      if (busy) n++;
      if (done) begin g = 1'b1; p = product; break; end
      if (n == 10) begin start = 1'b1; op_a = 32'd100; op_b = 32'd200; end
      else begin start = 1'b0; end
      @(negedge clk);
    end
    start = 1'b0;
    check_run("ignore", n, g, p, 64'd63);
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) ndone++;
    end
    checks++;
    if (ndone !== 0 || product !== 64'd63) begin
      errors++; $display("FAIL ignore_extra got dones=%0d product=%h want 0 63", ndone, product);
    end
  endtask

  task automatic test_reset_mid;
    int n; int ndone; int nb; bit g; logic [63:0] p;
    @(negedge clk);
    start = 1'b1; op_a = 32'd11; op_b = 32'd13;
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL rstmid_busy_before got=%b want=1", busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 64'd0) begin
      errors++; $display("FAIL rstmid_async got busy=%b done=%b product=%h want 0 0 0",
                         busy, done, product);
    end
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0; nb = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) ndone++;
      if (busy) nb++;
    end
    checks++;
    if (ndone !== 0 || nb !== 0) begin
      errors++; $display("FAIL rstmid_quiet got dones=%0d busy=%0d want 0 0", ndone, nb);
    end
    do_mul(32'd6, 32'd7, n, g, p);
    check_run("rstmid_new", n, g, p, 64'd42);
  endtask

  task automatic test_back_to_back;
    int n; bit g; logic [63:0] p;
    @(negedge clk);
    start = 1'b1; op_a = 32'd5; op_b = 32'd6;
    @(negedge clk);
    n = 0; g = 1'b0; p = '0;
    for (int i = 0; i < 100; i++) begin
      if (busy) n++;
      if (done) begin g = 1'b1; p = product; break; end
      @(negedge clk);
    end
    check_run("b2b_first", n, g, p, 64'd30);
    // Still holding start in the done cycle; new operands are captured at this edge.
    op_a = 32'd2; op_b = 32'd4;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || product !== 64'd30 || done !== 1'b0) begin
      errors++; $display("FAIL b2b_restart got busy=%b product=%h done=%b want 1 30 0",
                         busy, product, done);
    end
    n = 0; g = 1'b0; p = '0;
    for (int i = 0; i < 100; i++) begin
      if (busy) n++;
      if (done) begin g = 1'b1; p = product; break; end
      @(negedge clk);
    end
    check_run("b2b_second", n, g, p, 64'd8);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_zero();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
